// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states, bubble counter width.
// No logic; latency and backpressure are defined by the modules that import it.
package hazard_pkg;

  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'b00,
    HZ_LU_STALL = 2'b01,
    HZ_MEM_WAIT = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding source select for one E-stage operand; combinational, zero latency.
// M result beats W; x0 and non-writing stages are never sources; no backpressure.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (reg_write_m && (rd_m == rs))      sel = FWD_M;
      else if (reg_write_w && (rd_w == rs)) sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller (forwarding, load-use stall, dmem freeze, flushes); outputs same-cycle.
// dmem_busy_m freezes the whole pipe and defers redirects; optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              rs1_used_d,
  input  logic              rs2_used_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              mem_read_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              dmem_busy_m,
  input  logic              branch_taken_e,
  input  logic              jump_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LOAD_LAT - 1);

  fwd_sel_t fwd_a, fwd_b;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(rs1_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .sel(fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(rs2_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .sel(fwd_b)
  );

  hz_state_t            state, state_nxt, ret_state, ret_nxt, eff_state;
  logic [LAT_CNT_W-1:0] lu_cnt, lu_cnt_nxt;
  logic                 flush_pend, flush_pend_nxt;
  logic                 lu, redirect;
  logic                 st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w;

  assign lu = mem_read_e && (rd_e != '0) &&
              ((rs1_used_d && (rd_e == rs1_d)) || (rs2_used_d && (rd_e == rs2_d)));

  // While frozen, the remembered state is the one that resumes on exit.
  assign eff_state = (state == HZ_MEM_WAIT) ? ret_state : state;
  assign redirect  = branch_taken_e | flush_pend;

  always_comb begin
    state_nxt      = eff_state;
    ret_nxt        = ret_state;
    lu_cnt_nxt     = lu_cnt;
    flush_pend_nxt = flush_pend;
    st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
    fl_d = 1'b0; fl_e = 1'b0; fl_w = 1'b0;
    if (dmem_busy_m) begin
      st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1;
      fl_w = 1'b1;
      state_nxt = HZ_MEM_WAIT;
      ret_nxt   = eff_state;
      if (branch_taken_e || jump_d) flush_pend_nxt = 1'b1;
    end else begin
      flush_pend_nxt = 1'b0;
      fl_d = redirect | jump_d;
      fl_e = redirect;
      if (redirect) begin
        state_nxt  = HZ_IDLE;
        lu_cnt_nxt = '0;
      end else if (eff_state == HZ_LU_STALL) begin
        st_f = 1'b1;
        fl_e = 1'b1;
        lu_cnt_nxt = lu_cnt - LAT_CNT_W'(1);
        if (lu_cnt == LAT_CNT_W'(1)) state_nxt = HZ_IDLE;
      end else if (lu) begin
        st_f = 1'b1;
        fl_e = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt  = HZ_LU_STALL;
          lu_cnt_nxt = LAT_INIT;
        end
      end
      // A flushed D slot must not also be held.
      st_d = st_f & ~fl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HZ_IDLE;
      ret_state  <= HZ_IDLE;
      lu_cnt     <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      ret_state  <= ret_nxt;
      lu_cnt     <= lu_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  assign fwd_a_e = rst_n ? fwd_a : FWD_RF;
  assign fwd_b_e = rst_n ? fwd_b : FWD_RF;
  assign stall_f = rst_n & st_f;
  assign stall_d = rst_n & st_d;
  assign stall_e = rst_n & st_e;
  assign stall_m = rst_n & st_m;
  assign flush_d = rst_n & fl_d;
  assign flush_e = rst_n & fl_e;
  assign flush_w = rst_n & fl_w;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((st_f || st_d || st_e || st_m) && (stall_cyc_q != '1))
        stall_cyc_q <= stall_cyc_q + CNT_W'(1);
      if (fl_d && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances on shared inputs, checked each cycle
// against a bubble-count reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rs1_used_d, rs2_used_d, mem_read_e, reg_write_m, reg_write_w;
  logic       dmem_busy_m, branch_taken_e, jump_d;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1;
  logic        sf3, sd3, se3, sm3, fd3, fe3, fw3;
  logic [31:0] ps1, pf1, ps3, pf3;

  int errors = 0;
  int checks = 0;
  int rem[2];
  bit pend[2];
  int st_cnt1, st_cnt3;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .mem_read_e(mem_read_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .dmem_busy_m(dmem_busy_m),
    .branch_taken_e(branch_taken_e), .jump_d(jump_d), .fwd_a_e(fa1), .fwd_b_e(fb1),
    .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
    .flush_d(fd1), .flush_e(fe1), .flush_w(fw1),
    .perf_stall_cyc(ps1), .perf_flush_cnt(pf1)
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .mem_read_e(mem_read_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .dmem_busy_m(dmem_busy_m),
    .branch_taken_e(branch_taken_e), .jump_d(jump_d), .fwd_a_e(fa3), .fwd_b_e(fb3),
    .stall_f(sf3), .stall_d(sd3), .stall_e(se3), .stall_m(sm3),
    .flush_d(fd3), .flush_e(fe3), .flush_w(fw3),
    .perf_stall_cyc(ps3), .perf_flush_cnt(pf3)
  );

  wire [10:0] obs1 = {fa1, fb1, sf1, sd1, se1, sm1, fd1, fe1, fw1};
  wire [10:0] obs3 = {fa3, fb3, sf3, sd3, se3, sm3, fd3, fe3, fw3};

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (reg_write_m && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // rem = bubbles still owed after this cycle's; pend = redirect seen while frozen.
  function automatic void model(input int k, output logic [10:0] e, output int nr, output bit np);
    bit lu, red, sf, sd, se, sm, fd, fe, fw;
    int lat;
    lat = (k == 0) ? 1 : 3;
    nr = rem[k];
    np = pend[k];
    {sf, sd, se, sm, fd, fe, fw} = '0;
    e = '0;
    if (!rst_n) begin
      nr = 0;
      np = 1'b0;
      return;
    end
    lu = mem_read_e && rd_e != 5'd0 &&
         ((rs1_used_d && rd_e == rs1_d) || (rs2_used_d && rd_e == rs2_d));
    if (dmem_busy_m) begin
      {sf, sd, se, sm, fw} = 5'b11111;
      np = pend[k] | branch_taken_e | jump_d;
    end else begin
      red = branch_taken_e | pend[k];
      np  = 1'b0;
      fd  = red | jump_d;
      fe  = red;
      if (red) nr = 0;
      else if (rem[k] > 0) begin sf = 1'b1; fe = 1'b1; nr = rem[k] - 1; end
      else if (lu) begin sf = 1'b1; fe = 1'b1; nr = lat - 1; end
      sd = sf & ~fd;
    end
    e = {fwd_exp(rs1_e), fwd_exp(rs2_e), sf, sd, se, sm, fd, fe, fw};
  endfunction

  task automatic set_idle();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_used_d = 1'b0; rs2_used_d = 1'b0;
    rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0; mem_read_e = 1'b0;
    rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    dmem_busy_m = 1'b0; branch_taken_e = 1'b0; jump_d = 1'b0;
  endtask

  task automatic set_lw_add();
    mem_read_e = 1'b1; rd_e = 5'd5;
    rs1_d = 5'd5; rs2_d = 5'd7; rs1_used_d = 1'b1; rs2_used_d = 1'b1;
  endtask

  task automatic rand_inputs();
    rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
    rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
    rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
    rd_w  = 5'($urandom_range(0, 3));
    rs1_used_d = 1'($urandom); rs2_used_d = 1'($urandom); mem_read_e = 1'($urandom);
    reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
    dmem_busy_m    = ($urandom_range(0, 5) == 0);
    branch_taken_e = ($urandom_range(0, 7) == 0);
    jump_d         = ($urandom_range(0, 7) == 0);
  endtask

  // Inputs are already driven; sample at negedge, advance the model at posedge.
  task automatic tick(input string tag);
    logic [10:0] e0, e1;
    int nr0, nr1;
    bit np0, np1;
    @(negedge clk);
    model(0, e0, nr0, np0);
    model(1, e1, nr1, np1);
    checks++;
    assert (obs1 === e0) else begin
      errors++; $error("FAIL %s lat1 got=%b want=%b", tag, obs1, e0);
    end
    checks++;
    assert (obs3 === e1) else begin
      errors++; $error("FAIL %s lat3 got=%b want=%b", tag, obs3, e1);
    end
    checks++;
    assert ({ps1, pf1, ps3, pf3} === 128'd0) else begin
      errors++; $error("FAIL %s perf got=%h want=0", tag, {ps1, pf1, ps3, pf3});
    end
    if (sf1) st_cnt1++;
    if (sf3) st_cnt3++;
    @(posedge clk);
    rem[0] = nr0; pend[0] = np0;
    rem[1] = nr1; pend[1] = np1;
    #1;
  endtask

  initial begin
    rem = '{0, 0};
    pend = '{1'b0, 1'b0};
    set_idle();
    set_lw_add();
    reg_write_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3; dmem_busy_m = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({obs1, obs3} === 22'd0) else begin
      errors++; $error("FAIL reset_outs got=%b want=0", {obs1, obs3});
    end
    tick("reset0");
    tick("reset1");
    rst_n = 1'b1;
    set_idle();
    tick("idle");

    // lw x5 / add x6,x5,x7: bubble count per LOAD_LAT, then W forwarding.
    st_cnt1 = 0; st_cnt3 = 0;
    set_lw_add();                                  tick("lu_c1");
    mem_read_e = 1'b0; rd_e = 5'd0; rd_m = 5'd5; reg_write_m = 1'b1;
                                                   tick("lu_c2");
    rs1_e = 5'd5; rs2_e = 5'd7; rd_m = 5'd0; reg_write_m = 1'b0;
    rd_w = 5'd5; reg_write_w = 1'b1; rs1_used_d = 1'b0; rs2_used_d = 1'b0;
                                                   tick("lu_fwd_w");
    set_idle();                                    tick("lu_c4");
                                                   tick("lu_c5");
    checks++;
    assert (st_cnt1 === 1) else begin
      errors++; $error("FAIL lu_bubbles_lat1 got=%0d want=1", st_cnt1);
    end
    checks++;
    assert (st_cnt3 === 3) else begin
      errors++; $error("FAIL lu_bubbles_lat3 got=%0d want=3", st_cnt3);
    end

    // Forwarding priority and x0 filtering.
    rs1_e = 5'd0; rd_m = 5'd0; reg_write_m = 1'b1;  tick("fwd_x0");
    rs1_e = 5'd2; rs2_e = 5'd9; rd_m = 5'd9; rd_w = 5'd9; reg_write_w = 1'b1;
                                                   tick("fwd_m_over_w");
    reg_write_m = 1'b0;                            tick("fwd_w_only");
    set_idle();

    // lui x5 after lw x5: no source used, no stall; load to x0: no stall.
    mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd5;
                                                   tick("lui_no_stall");
    rd_e = 5'd0; rs1_d = 5'd0; rs1_used_d = 1'b1;  tick("ld_x0_no_stall");
    set_idle();

    // Freeze 4 cycles with a branch in cycle 2, deferred flush on exit.
    dmem_busy_m = 1'b1;                            tick("busy_c1");
    branch_taken_e = 1'b1;                         tick("busy_c2_br");
    branch_taken_e = 1'b0;                         tick("busy_c3");
                                                   tick("busy_c4");
    dmem_busy_m = 1'b0;                            tick("busy_exit_flush");
                                                   tick("busy_after");

    // Freeze in the middle of a multi-cycle load stall keeps remaining bubbles.
    set_lw_add();                                  tick("lu_busy_c1");
    mem_read_e = 1'b0; rd_e = 5'd0; dmem_busy_m = 1'b1;
                                                   tick("lu_busy_f1");
                                                   tick("lu_busy_f2");
    dmem_busy_m = 1'b0;                            tick("lu_busy_r1");
                                                   tick("lu_busy_r2");
                                                   tick("lu_busy_r3");
    set_idle();

    // Jump in D during load-use: flush wins over stall_d; branch overrides load-use.
    set_lw_add(); jump_d = 1'b1;                   tick("lu_jump");
    jump_d = 1'b0; mem_read_e = 1'b0; rd_e = 5'd0; tick("lu_jump_c2");
    set_idle(); set_lw_add(); branch_taken_e = 1'b1; tick("lu_branch");
    set_idle();                                    tick("lu_branch_c2");

    // Async reset during LOAD_LAT=3 stall with bubbles still owed.
    set_lw_add();                                  tick("rst_lu_c1");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({obs1, obs3} === 22'd0) else begin
      errors++; $error("FAIL async_rst_outs got=%b want=0", {obs1, obs3});
    end
    tick("rst_hold");
    rst_n = 1'b1;
    set_idle();                                    tick("rst_after_idle");
                                                   tick("rst_after_idle2");

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
